// File: rtl/fns_cac_enc_seq_if.sv
// rtl/fns_cac_enc_seq_if.sv - word/fault input and TSV drive bundle of the FNS encoder
interface fns_cac_enc_seq_if #(
  parameter int DATA_W = 7,
  parameter int CODE_W = 9,
  parameter int N_TSV  = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] datain;
  logic [N_TSV-1:0]  fault_flag;
  logic [N_TSV-1:0]  tsv;
  logic [N_TSV-1:0]  en_flag;
  logic              tsv_valid;
  logic              err_valid;
  logic [1:0]        err_code;

  modport master (
    output in_valid, datain, fault_flag,
    input  in_ready, tsv, en_flag, tsv_valid, err_valid, err_code
  );

  modport slave (
    input  in_valid, datain, fault_flag,
    output in_ready, tsv, en_flag, tsv_valid, err_valid, err_code
  );
endinterface

// File: rtl/fns_cac_enc_seq.sv
// rtl/fns_cac_enc_seq.sv - sequential Zeckendorf encoder with fault-skipping TSV mapping
module fns_cac_enc_seq #(
  parameter int DATA_W = 7,
  parameter int CODE_W = 9,
  parameter int N_TSV  = 12
) (
  input  logic             clock,
  input  logic             rst_n,
  fns_cac_enc_seq_if.slave bus
);
  // Fibonacci weight n with w0=1, w1=2
  function automatic logic [63:0] fib_w(input int n);
    logic [63:0] a, b, t;
    a = 64'd1;
    b = 64'd2;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  localparam logic [63:0] W_TOP = fib_w(CODE_W);
  localparam int WT_W  = $clog2(W_TOP + 64'd1);
  localparam int CMP_W = (WT_W > DATA_W) ? WT_W : DATA_W;
  localparam logic [CMP_W-1:0] MAXVAL = CMP_W'(W_TOP - 64'd1);
  localparam int KW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int JW = $clog2(CODE_W + 1);
  localparam int N_SPARE = N_TSV - CODE_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ENC  = 2'd1;
  localparam logic [1:0] S_MAP  = 2'd2;

  logic [1:0]       state;
  logic [CMP_W-1:0] rem_q;
  logic [CODE_W-1:0] code_q;
  logic [KW-1:0]    k_q;
  logic [N_TSV-1:0] flt_q;
  logic [N_TSV-1:0] tsv_q, en_q;
  logic             tsv_valid_q, err_valid_q;
  logic [1:0]       err_code_q;

  logic [CMP_W-1:0] w_tab [CODE_W];
  for (genvar g = 0; g < CODE_W; g++) begin : g_wt
    assign w_tab[g] = CMP_W'(fib_w(g));
  end

  int   n_fault;
  logic ovf, spr;
  always_comb begin
    n_fault = 0;
    for (int i = 0; i < N_TSV; i++) n_fault += 32'(bus.fault_flag[i]);
  end
  assign ovf = CMP_W'(bus.datain) > MAXVAL;
  assign spr = n_fault > N_SPARE;

  // Code bit j lands on the j-th healthy TSV; surplus healthy spares stay disabled
  logic [N_TSV-1:0] map_tsv, map_en;
  logic [JW-1:0]    j_idx;
  always_comb begin
    map_tsv = '0;
    map_en  = '0;
    j_idx   = '0;
    for (int i = 0; i < N_TSV; i++) begin
      if (!flt_q[i] && (j_idx < JW'(CODE_W))) begin
        map_tsv[i] = code_q[j_idx[KW-1:0]];
        map_en[i]  = 1'b1;
        j_idx      = j_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rem_q       <= '0;
      code_q      <= '0;
      k_q         <= '0;
      flt_q       <= '0;
      tsv_q       <= '0;
      en_q        <= '0;
      tsv_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      tsv_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (ovf || spr) begin
              err_valid_q <= 1'b1;
              err_code_q  <= {spr, ovf};
            end else begin
              rem_q  <= CMP_W'(bus.datain);
              flt_q  <= bus.fault_flag;
              code_q <= '0;
              k_q    <= KW'(CODE_W - 1);
              state  <= S_ENC;
            end
          end
        end
        S_ENC: begin
          if (rem_q >= w_tab[k_q]) begin
            code_q[k_q] <= 1'b1;
            rem_q       <= rem_q - w_tab[k_q];
          end
          if (k_q == '0) state <= S_MAP;
          else           k_q   <= k_q - 1'b1;
        end
        S_MAP: begin
          tsv_q       <= map_tsv;
          en_q        <= map_en;
          tsv_valid_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.tsv       = tsv_q;
  assign bus.en_flag   = en_q;
  assign bus.tsv_valid = tsv_valid_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_fns_cac_enc_seq.sv
// tb/tb_fns_cac_enc_seq.sv - self-checking bench for fns_cac_enc_seq
module tb_fns_cac_enc_seq;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [11:0] cur_tsv, cur_en;

  fns_cac_enc_seq_if #(.DATA_W(7), .CODE_W(9), .N_TSV(12)) bus ();

  fns_cac_enc_seq #(.DATA_W(7), .CODE_W(9), .N_TSV(12)) dut (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] f;
    logic [6:0]  d;
    logic [11:0] et;
    logic [11:0] ee;
    logic [1:0]  ec;
  } vec_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endfunction

  // Greedy Zeckendorf from plain integers, then place bits on the healthy TSV list
  function automatic void model(input logic [11:0] f, input int d,
                                output logic [11:0] et, output logic [11:0] ee,
                                output logic [1:0] ec);
    int w[10];
    int rem;
    int healthy[$];
    logic [8:0] code;
    w[0] = 1;
    w[1] = 2;
    for (int i = 2; i < 10; i++) w[i] = w[i-1] + w[i-2];
    ec = {($countones(f) > 3), (d > w[9] - 1)};
    et = cur_tsv;
    ee = cur_en;
    if (ec != 2'b00) return;
    rem  = d;
    code = '0;
    for (int k = 8; k >= 0; k--) if (rem >= w[k]) begin code[k] = 1'b1; rem -= w[k]; end
    for (int i = 0; i < 12; i++) if (!f[i]) healthy.push_back(i);
    et = '0;
    ee = '0;
    for (int b = 0; b < 9; b++) begin
      ee[healthy[b]] = 1'b1;
      et[healthy[b]] = code[b];
    end
  endfunction

  function automatic logic [8:0] unmap(input logic [11:0] t, input logic [11:0] e);
    int j = 0;
    logic [8:0] c = '0;
    for (int i = 0; i < 12; i++) if (e[i] && j < 9) begin c[j] = t[i]; j++; end
    return c;
  endfunction

  always @(negedge clk) if (bus.tsv_valid && bus.err_valid) check("pulse_excl", 32'd1, 32'd0);

  task automatic do_word(input logic [11:0] f, input logic [6:0] d, input logic [11:0] et,
                         input logic [11:0] ee, input logic [1:0] ec, input string tag);
    int   lat;
    logic bad_ready;
    logic [8:0] c;
    @(negedge clk);
    check({tag, ".ready_pre"}, bus.in_ready, 1);
    bus.in_valid   = 1'b1;
    bus.datain     = d;
    bus.fault_flag = f;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.datain     = 7'($urandom);
    bus.fault_flag = 12'($urandom);
    if (ec != 2'b00) begin
      check({tag, ".err_valid"}, bus.err_valid, 1);
      check({tag, ".err_code"}, bus.err_code, ec);
      check({tag, ".ready"}, bus.in_ready, 1);
      check({tag, ".tsv_hold"}, bus.tsv, et);
      check({tag, ".en_hold"}, bus.en_flag, ee);
      @(negedge clk);
      check({tag, ".err_pulse"}, bus.err_valid, 0);
    end else begin
      lat = 0;
      bad_ready = 1'b0;
      while (!bus.tsv_valid && lat < 20) begin
        if (bus.in_ready) bad_ready = 1'b1;
        @(negedge clk);
        lat++;
      end
      check({tag, ".ready_low"}, bad_ready, 0);
      check({tag, ".latency"}, lat, 10);
      check({tag, ".tsv"}, bus.tsv, et);
      check({tag, ".en"}, bus.en_flag, ee);
      check({tag, ".ready_back"}, bus.in_ready, 1);
      check({tag, ".en_pop"}, $countones(bus.en_flag), 9);
      check({tag, ".tsv_in_en"}, bus.tsv & ~bus.en_flag, 0);
      c = unmap(bus.tsv, bus.en_flag);
      check({tag, ".no_adj"}, c & (c >> 1), 0);
      @(negedge clk);
      check({tag, ".tsv_pulse"}, bus.tsv_valid, 0);
      cur_tsv = et;
      cur_en  = ee;
    end
  endtask

  initial begin
    vec_t tbl[9];
    logic [11:0] et, ee, f;
    logic [1:0]  ec;
    logic [6:0]  bb[3];
    int acc[3];
    int d, t;
    logic got, saw;

    n_chk = 0;
    n_pass = 0;
    cur_tsv = '0;
    cur_en = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.datain = '0;
    bus.fault_flag = '0;
    repeat (2) @(negedge clk);
    check("rst.tsv", bus.tsv, 0);
    check("rst.en", bus.en_flag, 0);
    check("rst.tsv_valid", bus.tsv_valid, 0);
    check("rst.err_valid", bus.err_valid, 0);
    check("rst.err_code", bus.err_code, 0);
    check("rst.ready", bus.in_ready, 1);
    rst_n = 1'b1;

    tbl[0] = '{12'h000, 7'd0,   12'h000, 12'h1FF, 2'b00};
    tbl[1] = '{12'h000, 7'd63,  12'h110, 12'h1FF, 2'b00};
    tbl[2] = '{12'h000, 7'd88,  12'h155, 12'h1FF, 2'b00};
    tbl[3] = '{12'h001, 7'd63,  12'h220, 12'h3FE, 2'b00};
    tbl[4] = '{12'h001, 7'd1,   12'h002, 12'h3FE, 2'b00};
    tbl[5] = '{12'h821, 7'd20,  12'h094, 12'h7DE, 2'b00};
    tbl[6] = '{12'h00F, 7'd5,   12'h094, 12'h7DE, 2'b10};
    tbl[7] = '{12'h000, 7'd100, 12'h094, 12'h7DE, 2'b01};
    tbl[8] = '{12'h00F, 7'd100, 12'h094, 12'h7DE, 2'b11};
    for (int i = 0; i < 9; i++)
      do_word(tbl[i].f, tbl[i].d, tbl[i].et, tbl[i].ee, tbl[i].ec, $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      f = '0;
      t = $urandom_range(0, 4);
      for (int b = 0; b < t; b++) f[$urandom_range(0, 11)] = 1'b1;
      d = $urandom_range(0, 110);
      model(f, d, et, ee, ec);
      do_word(f, 7'(d), et, ee, ec, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of encoding drops the word
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.datain = 7'd50;
    bus.fault_flag = '0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst.tsv", bus.tsv, 0);
    check("mid_rst.en", bus.en_flag, 0);
    check("mid_rst.tsv_valid", bus.tsv_valid, 0);
    check("mid_rst.err_code", bus.err_code, 0);
    check("mid_rst.ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.tsv_valid) saw = 1'b1;
    end
    check("mid_rst.no_valid", saw, 0);
    cur_tsv = '0;
    cur_en = '0;

    // Back-to-back with in_valid held and fault_flag churning during ENC
    bb[0] = 7'd3;
    bb[1] = 7'd7;
    bb[2] = 7'd12;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.datain = bb[0];
    bus.fault_flag = '0;
    for (int w = 0; w < 3; w++) begin
      t = 0;
      while (!bus.in_ready && t < 30) begin @(negedge clk); t++; end
      @(posedge clk);
      acc[w] = int'($time / 10);
      @(negedge clk);
      if (w < 2) bus.datain = bb[w+1];
      else bus.in_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        bus.fault_flag = 12'($urandom);
        @(posedge clk);
        @(negedge clk);
        if (bus.tsv_valid) begin
          got = 1'b1;
          bus.fault_flag = '0;
          model(12'h000, int'(bb[w]), et, ee, ec);
          check($sformatf("b2b%0d.tsv", w), bus.tsv, et);
          check($sformatf("b2b%0d.en", w), bus.en_flag, ee);
        end
      end
      check($sformatf("b2b%0d.done", w), got, 1);
      if (w > 0) check($sformatf("b2b%0d.spacing", w), acc[w] - acc[w-1], 11);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fns_cac_enc_seq.md
Name: fns_cac_enc_seq

Overview:
- Parametrised sequential Fibonacci-numeral-system (FNS) encoder for fault-tolerant TSV arrays.
- Converts a binary word into a CODE_W-bit Zeckendorf codeword using greedy subtraction, one weight per cycle.
- Maps each code bit onto the next non-faulty TSV in ascending order and drives the physical TSV bundle and its enable mask.
- Succeeds the fixed-width combinational coder: width, code length and TSV count are generic, there is a valid/ready handshake, and fault/overflow errors are reported.

Parameters:
- DATA_W, 7: input word width.
- CODE_W, 9: FNS codeword length (weights w0=1, w1=2, wk=wk-1+wk-2).
- N_TSV, 12: physical TSVs, including N_TSV-CODE_W spares. Requirement: N_TSV >= CODE_W.

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word (high only in IDLE)
- datain  in  DATA_W  binary word
- fault_flag  in  N_TSV  1 = TSV faulty; bit 0 = first TSV
- tsv  out  N_TSV  registered TSV drive
- en_flag  out  N_TSV  registered mask of TSVs carrying code bits
- tsv_valid  out  1  one-cycle pulse when tsv/en_flag update
- err_valid  out  1  one-cycle pulse on rejected word
- err_code  out  2  01 overflow, 10 insufficient spares, 11 both

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; tsv=0, en_flag=0, tsv_valid=0, err_valid=0, err_code=0; internal remainder, code and index registers cleared.
- Reset mid-operation discards the word. No tsv_valid is produced for it.
- MAXVAL = w_CODE_W - 1 (88 for CODE_W=9).
- All comparisons and subtractions are done at a width that holds w_CODE_W and DATA_W without truncation.
- FSM states: IDLE, ENC, MAP.
- IDLE:
  - in_ready=1.
  - On in_valid at edge E: latch datain and fault_flag.
  - Overflow check: datain > MAXVAL.
  - Spare check: popcount(fault_flag) > N_TSV-CODE_W.
  - If either check fails: stay in IDLE, err_valid=1 for one cycle after E, err_code set accordingly; tsv and en_flag unchanged.
  - Otherwise: go to ENC with k=CODE_W-1 and code cleared.
- ENC, one edge per k:
  - If rem >= w_k: code[k]=1 and rem -= w_k; else code[k]=0.
  - When k==0, go to MAP.
  - Takes CODE_W edges.
- MAP, one edge:
  - Code bit i drives the i-th healthy TSV, counting ascending from TSV0.
  - Faulty TSVs and unused healthy spares drive 0 with en_flag=0.
  - The CODE_W used TSVs have en_flag=1.
  - tsv and en_flag update atomically; tsv_valid=1 for one cycle; return to IDLE.
- Latency: word accepted at edge E; outputs update at edge E+CODE_W+1.
- in_ready is low from after E until after E+CODE_W+1. The next accept is possible at E+CODE_W+2, so throughput is one word per CODE_W+2 cycles.
- fault_flag and datain changes after acceptance are ignored until the next accept.
- tsv and en_flag hold their value between updates.
- Invariants (bench assertions):
  - The pre-mapping codeword never contains two adjacent 1s.
  - popcount(en_flag) == CODE_W after the first successful word.
  - tsv & ~en_flag == 0.
  - tsv_valid and err_valid are never both high.

Test Plan:
- Reset, fault_flag=0, datain=0 -> tsv=0x000, en_flag=0x1FF, tsv_valid pulse exactly at edge E+10, in_ready low for edges E+1..E+10.
- fault_flag=0, datain=63 -> code=0x110 (55+8), tsv=0x110, en_flag=0x1FF. datain=88 -> code=0x155, tsv=0x155.
- fault_flag=0x001: datain=63 -> tsv=0x220, en_flag=0x3FE. datain=1 -> tsv=0x002.
- fault_flag=0x821 (TSVs 0,5,11), datain=20 -> code=0x02A (13+5+2), tsv=0x094, en_flag=0x7DE.
- Error cases, with tsv/en_flag unchanged and in_ready staying 1 in each:
  - fault_flag=0x00F, datain=5 -> err_valid pulse, err_code=10.
  - fault_flag=0, datain=100 -> err_code=01.
  - fault_flag=0x00F, datain=100 -> err_code=11.
- rst_n asserted at E+4 mid-ENC -> no tsv_valid, all outputs 0, in_ready=1 immediately. in_valid held high with data 3,7,12 back-to-back -> accepts every 11 cycles; fault_flag toggled during ENC has no effect on the produced mapping.
